viterbi_codec: RTL and testbench
================================

Name: viterbi_codec

Overview:
- Rate-1/2 convolutional encoder and matching hard-decision Viterbi decoder in one block.
- Constraint length K=3, generators G1=111 (octal 7) and G0=101 (octal 5).
- The encoder path and the decoder path are independent. The system links them externally through a channel that may corrupt bits, normally with one register stage: dec_enable_i = enc_valid_o delayed 1 cycle, dec_d_i = enc_d_o delayed 1 cycle.

Parameters:
- TB_DEPTH, 16, survivor (register-exchange) depth; sets decoder latency. Legal range 8..32.
- PM_W, 7, path-metric width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- enc_enable_i  input  1  encoder accepts enc_d_i this cycle.
- enc_d_i  input  1  information bit.
- enc_valid_o  output  1  enc_d_o carries a new symbol.
- enc_d_o  output  2  code symbol: [1]=G1 output, [0]=G0 output.
- dec_enable_i  input  1  decoder accepts dec_d_i this cycle.
- dec_d_i  input  2  received hard symbol, same bit order as enc_d_o.
- dec_valid_o  output  1  dec_d_o holds a decoded bit.
- dec_d_o  output  1  decoded information bit.

Behaviour:

Reset:
- All outputs are 0 and the encoder shift register is 00.
- Path metrics: state 0 = 0; states 1..3 = 2^(PM_W-1)-1.
- Survivors are all 0 and the symbol counter is 0.

Encoder:
- State (s1,s0): s1 is the previous bit, s0 is the bit before it.
- On a clk edge with enc_enable_i=1:
  - enc_d_o[1] <= d ^ s1 ^ s0
  - enc_d_o[0] <= d ^ s0
  - state <= (d, s1)
  - enc_valid_o <= 1
- With enc_enable_i=0: state and enc_d_o hold, and enc_valid_o <= 0.
- Latency is 1 cycle; back-to-back enables produce one symbol per cycle.

Decoder trellis:
- 4 states, numbered 2*s1+s0.
- From state (s1,s0), input b goes to (b,s1) with expected symbol {b^s1^s0, b^s0}.
- Each state has 2 predecessors: (s1', 0) and (s1', 1), where s1' is the new state's s0.

Decoder per accepted symbol (dec_enable_i=1):
- Branch metric = Hamming distance (0..2) between dec_d_i and the expected symbol.
- ACS: new PM = min over both predecessors of (PM + BM). On a tie, select the predecessor with s0=0.
- Normalization: subtract the minimum of the 4 new metrics from all of them before storing, so the best state is always 0.
- Metrics saturate at 2^PM_W-1; they never wrap.
- Survivor update: surv[new] = {surv[pred][TB_DEPTH-2:0], b}, where b = the new state's s1.
- Best state = the minimum new PM; ties go to the lowest index.
- dec_d_o <= MSB of surv[best], using the newly computed survivors in the same edge.
- The symbol counter increments and saturates at TB_DEPTH.
- dec_valid_o <= 1 when the counter (after the increment) >= TB_DEPTH; otherwise 0.

Decoder with dec_enable_i=0:
- Metrics, survivors, counter and dec_d_o hold.
- dec_valid_o <= 0.

Latency and output timing:
- On the edge accepting symbol n (0-based), dec_d_o becomes the estimate of information bit n-(TB_DEPTH-1).
- The first valid output appears on symbol TB_DEPTH-1.
- Idle gaps on dec_enable_i do not change bit alignment.

Reset mid-stream:
- Asserting rst restores the reset state immediately (asynchronous).
- After release, both paths restart as from power-up.

Error correction:
- Free distance is 5.
- Any single channel bit error, and any two bit errors, separated from other errors by at least 2*TB_DEPTH symbols, must be corrected.

Test Plan:
- Encoder only, reset then enables with bits 1,0,1,1,0,0 -> enc_d_o = 11,10,00,01,01,11; enc_valid_o high 1 cycle after each enable.
- Clean loop, 256 random bits with the 1-cycle channel register -> dec_d_o matches input delayed TB_DEPTH-1 accepted symbols; zero mismatches once dec_valid_o=1.
- Channel flips bit [1] of one symbol at index 150 -> zero decoded mismatches.
- Channel flips bit [1] on symbols 151 and 152 (two errors) -> zero decoded mismatches. Also flip on symbols 151..154 (4 errors) -> no hang; output realigns with zero mismatches from symbol 154+2*TB_DEPTH onward.
- Random dec_enable_i gaps (e.g. 1 on, 2 off) on a clean stream -> same decoded sequence as the gapless run; dec_valid_o pulses only on enabled cycles.
- Reset asserted mid-stream at symbol 40 -> all outputs 0 immediately; after release dec_valid_o stays 0 until TB_DEPTH new symbols, then decoding is correct.

Source files
------------

// File: rtl/viterbi_codec_if.sv
// rtl/viterbi_codec_if.sv - encoder and decoder stream signals of viterbi_codec
interface viterbi_codec_if;
    logic       enc_enable_i;
    logic       enc_d_i;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i;
    logic [1:0] dec_d_i;
    logic       dec_valid_o;
    logic       dec_d_o;

    modport slave (
        input  enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        output enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
    );

    modport master (
        output enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        input  enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
    );
endinterface

// File: rtl/viterbi_codec.sv
// rtl/viterbi_codec.sv - K=3 rate-1/2 (7,5) convolutional encoder and hard-decision Viterbi decoder
module viterbi_codec #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 7
) (
    input  logic            clk,
    input  logic            rst,
    viterbi_codec_if.slave  bus
);
    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
    localparam logic [PM_W-1:0]  PM_MAX  = '1;
    localparam logic [PM_W-1:0]  PM_INIT = {1'b0, {(PM_W-1){1'b1}}};

    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] e);
        logic [1:0] x;
        x = a ^ e;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return s[PM_W] ? PM_MAX : s[PM_W-1:0];
    endfunction

    logic [1:0]          r_enc_s;
    logic [1:0]          r_enc_d;
    logic                r_enc_valid;

    logic [PM_W-1:0]     r_pm   [4];
    logic [TB_DEPTH-1:0] r_surv [4];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_dec_valid;
    logic                r_dec_d;

    logic [PM_W-1:0]     w_pm_new   [4];
    logic [TB_DEPTH-1:0] w_surv_new [4];
    logic [PM_W-1:0]     w_min;
    logic [1:0]          w_best;
    logic [CNT_W-1:0]    w_cnt_nxt;

    assign bus.enc_valid_o = r_enc_valid;
    assign bus.enc_d_o     = r_enc_d;
    assign bus.dec_valid_o = r_dec_valid;
    assign bus.dec_d_o     = r_dec_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enc_s     <= 2'b00;
            r_enc_d     <= 2'b00;
            r_enc_valid <= 1'b0;
        end else if (bus.enc_enable_i) begin
            r_enc_d     <= {bus.enc_d_i ^ r_enc_s[1] ^ r_enc_s[0], bus.enc_d_i ^ r_enc_s[0]};
            r_enc_s     <= {bus.enc_d_i, r_enc_s[1]};
            r_enc_valid <= 1'b1;
        end else begin
            r_enc_valid <= 1'b0;
        end
    end

    // New state n = (b, s1'); its predecessors are (s1', 0) and (s1', 1).
    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam logic LB = 1'((n >> 1) & 1);
        localparam logic LS = 1'(n & 1);
        localparam int   P0 = 2 * (n % 2);
        localparam int   P1 = P0 + 1;

        logic [1:0]      w_bm0, w_bm1;
        logic [PM_W-1:0] w_c0, w_c1;
        logic            w_sel;

        assign w_bm0 = hamming(bus.dec_d_i, {LB ^ LS, LB});
        assign w_bm1 = hamming(bus.dec_d_i, {~(LB ^ LS), ~LB});
        assign w_c0  = sat_add(r_pm[P0], w_bm0);
        assign w_c1  = sat_add(r_pm[P1], w_bm1);
        assign w_sel = (w_c1 < w_c0);
        assign w_pm_new[n]   = w_sel ? w_c1 : w_c0;
        assign w_surv_new[n] = w_sel ? {r_surv[P1][TB_DEPTH-2:0], LB}
                                     : {r_surv[P0][TB_DEPTH-2:0], LB};
    end

    always_comb begin
        w_best = 2'd0;
        w_min  = w_pm_new[0];
        for (int i = 1; i < 4; i++) begin
            if (w_pm_new[i] < w_min) begin
                w_min  = w_pm_new[i];
                w_best = 2'(i);
            end
        end
    end

    assign w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_INIT;
                r_surv[i] <= '0;
            end
            r_cnt       <= '0;
            r_dec_valid <= 1'b0;
            r_dec_d     <= 1'b0;
        end else if (bus.dec_enable_i) begin
            // Normalising keeps the best metric at zero so saturation is only hit by hopeless paths.
            for (int i = 0; i < 4; i++) begin
                r_pm[i]   <= w_pm_new[i] - w_min;
                r_surv[i] <= w_surv_new[i];
            end
            r_cnt       <= w_cnt_nxt;
            r_dec_valid <= (w_cnt_nxt >= CNT_MAX);
            r_dec_d     <= w_surv_new[w_best][TB_DEPTH-1];
        end else begin
            r_dec_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_viterbi_codec.sv
// tb/tb_viterbi_codec.sv - scoreboard bench for viterbi_codec encoder and decoder paths
module tb_viterbi_codec;
    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 7;
    localparam int NBITS    = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_codec_if bus ();

    viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks     = 0;
    int   failures   = 0;
    int   pops       = 0;
    int   acc        = 0;
    int   skip_below = 0;
    bit   enc_chk    = 0;
    bit   exp_q [$];
    int   idx_q [$];
    logic [1:0] enc_q [$];
    bit   bits [NBITS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_enc_valid"}, 32'(bus.enc_valid_o), 32'd0);
        check({tag, "_enc_d"},     32'(bus.enc_d_o),     32'd0);
        check({tag, "_dec_valid"}, 32'(bus.dec_valid_o), 32'd0);
        check({tag, "_dec_d"},     32'(bus.dec_d_o),     32'd0);
    endtask

    // Monitor: samples 1 time unit after each rising edge and pops the scoreboards.
    initial begin
        logic en;
        bit   eb;
        int   ei;
        logic [1:0] es;
        forever begin
            @(posedge clk);
            en = bus.dec_enable_i;
            #1;
            if (!rst) begin
                acc = 0;
            end else begin
                if (en && acc < TB_DEPTH) acc++;
                check("dec_valid_timing", 32'(bus.dec_valid_o), 32'(en && acc >= TB_DEPTH));
                if (bus.dec_valid_o) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL dec_underflow actual=valid expected=no_output t=%0t", $time);
                    end else begin
                        eb = exp_q.pop_front();
                        ei = idx_q.pop_front();
                        pops++;
                        if (ei >= skip_below) check($sformatf("dec_bit%0d", ei), 32'(bus.dec_d_o), 32'(eb));
                    end
                end
                if (enc_chk && bus.enc_valid_o) begin
                    if (enc_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL enc_underflow actual=valid expected=no_output t=%0t", $time);
                    end else begin
                        es = enc_q.pop_front();
                        check("enc_symbol", 32'(bus.enc_d_o), 32'(es));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.enc_enable_i = 1'b0;
        bus.dec_enable_i = 1'b0;
        bus.dec_d_i      = 2'b00;
        @(negedge clk);
        exp_q.delete();
        idx_q.delete();
        pops = 0;
        rst  = 1'b1;
    endtask

    // Drives the encoder and a 1-cycle channel register into the decoder.
    task automatic run_stream(input string tag, input int on_cyc, input int off_cyc,
                              input int flo, input int fhi, input int rst_at);
        int sent  = 0;
        int sym   = 0;
        int phase = 0;
        int tail  = 0;
        bit did_rst = 0;
        while (sent < NBITS || tail < 3) begin
            @(negedge clk);
            bus.dec_enable_i = bus.enc_valid_o;
            bus.dec_d_i      = bus.enc_d_o;
            if (bus.enc_valid_o) begin
                if (sym >= flo && sym <= fhi) bus.dec_d_i[1] = ~bus.dec_d_i[1];
                sym++;
            end
            if (rst_at >= 0 && !did_rst && sent == rst_at) begin
                rst = 1'b0;
                #1;
                check_outputs_zero({tag, "_midrst"});
                bus.enc_enable_i = 1'b0;
                bus.dec_enable_i = 1'b0;
                @(negedge clk);
                exp_q.delete();
                idx_q.delete();
                pops = 0;
                rst = 1'b1;
                did_rst = 1;
                sent = 0;
                sym  = 0;
                phase = 0;
                continue;
            end
            if (sent < NBITS && phase < on_cyc) begin
                bus.enc_enable_i = 1'b1;
                bus.enc_d_i      = bits[sent];
                exp_q.push_back(bits[sent]);
                idx_q.push_back(sent);
                sent++;
            end else begin
                bus.enc_enable_i = 1'b0;
                bus.enc_d_i      = 1'b0;
                if (sent >= NBITS) tail++;
            end
            phase = (phase + 1) % (on_cyc + off_cyc);
        end
        repeat (3) @(negedge clk);
        check({tag, "_outputs"}, 32'(pops), 32'(NBITS - (TB_DEPTH - 1)));
        do_reset();
    endtask

    initial begin
        logic [1:0] enc_exp [6];
        bit         enc_in  [6];
        enc_in  = '{1, 0, 1, 1, 0, 0};
        enc_exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        for (int i = 0; i < NBITS; i++) bits[i] = 1'($urandom_range(0, 1));

        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        bus.dec_enable_i = 1'b0;
        bus.dec_d_i      = 2'b00;
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        enc_chk = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.enc_enable_i = 1'b1;
            bus.enc_d_i      = enc_in[k];
            enc_q.push_back(enc_exp[k]);
        end
        @(negedge clk);
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b1;
        @(negedge clk);
        check("enc_idle_valid", 32'(bus.enc_valid_o), 32'd0);
        check("enc_idle_hold",  32'(bus.enc_d_o),     32'd3);
        check("enc_all_popped", 32'(enc_q.size()),    32'd0);
        enc_chk = 0;
        do_reset();

        run_stream("clean",  1, 0, -1, -1, -1);
        run_stream("err1",   1, 0, 150, 150, -1);
        run_stream("err2",   1, 0, 151, 152, -1);
        skip_below = 154 + 2 * TB_DEPTH;
        run_stream("err4",   1, 0, 151, 154, -1);
        skip_below = 0;
        run_stream("gaps",   1, 2, -1, -1, -1);
        run_stream("midrst", 1, 0, -1, -1, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
